// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared state encodings and widths for the match controller
package match_pkg;

    // Encodings are visible on the state output, so they are fixed here.
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_KICKOFF      = 3'd1,
        ST_PLAY         = 3'd2,
        ST_GOAL_PAUSE   = 3'd3,
        ST_SUDDEN_DEATH = 3'd4,
        ST_GAME_OVER    = 3'd5
    } match_state_t;

    localparam int FRAME_W  = 16;
    localparam int WINNER_W = 2;

endpackage

// File: rtl/frame_down_counter.sv
// rtl/frame_down_counter.sv - loadable frame down-counter that holds at zero
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (count clears to 0)
//   load        - load load_value (wins over enable)
//   load_value  - value to load
//   enable      - decrement by one when set (normally frame_tick qualified by state)
//   count       - current count
//   zero        - count is zero
module frame_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - match sequencing: kickoff, play, goal pauses, timeout, sudden death
//
// Ports:
//   Clk, Reset_n - clock, asynchronous active-low reset
//   frame_tick   - one-cycle pulse per video frame
//   start        - level request to start a match; must drop to leave GAME_OVER
//   goal         - one-cycle pulse per player credited with a goal
//   score        - packed scores, player 0 in the LSBs
//   frames_left  - remaining regulation frames
//   state        - current state (match_pkg encoding)
//   round_reset  - one-cycle pulse repositioning ball and characters
//   play_en      - high in PLAY and SUDDEN_DEATH
//   winner       - winning player index, meaningful in GAME_OVER
module match_controller
    import match_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 5,
    parameter int MATCH_FRAMES = 5400,
    parameter int PAUSE_FRAMES = 120
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           frame_tick,
    input  logic                           start,
    input  logic [NUM_PLAYERS-1:0]         goal,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic [FRAME_W-1:0]             frames_left,
    output logic [2:0]                     state,
    output logic                           round_reset,
    output logic                           play_en,
    output logic [WINNER_W-1:0]            winner
);

    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [FRAME_W-1:0] MATCH_LOAD = FRAME_W'(MATCH_FRAMES);
    localparam logic [FRAME_W-1:0] PAUSE_LOAD = FRAME_W'(PAUSE_FRAMES);

    match_state_t state_q, state_d;

    logic [SCORE_W-1:0]  score_q [NUM_PLAYERS];
    logic [WINNER_W-1:0] winner_q, winner_d;
    logic                round_reset_q, round_reset_d;

    logic                load_reg, load_pause;
    logic                clear_scores, credit, set_winner;

    logic [FRAME_W-1:0]  pause_count;
    logic                reg_zero, pause_zero;
    logic                reg_tick, pause_tick;
    logic                reg_timeout, pause_done;

    logic                goal_valid;
    logic [WINNER_W-1:0] goal_idx;
    logic [SCORE_W-1:0]  goal_cur, goal_new;
    logic                goal_wins;

    logic [SCORE_W-1:0]  max_score;
    logic [WINNER_W-1:0] max_idx;
    logic [2:0]          max_count;

    // Regulation timer only runs in PLAY; it keeps counting on a goal cycle,
    // so a goal on the final tick leaves frames_left at 0 and the timeout is
    // then decided when play resumes.
    assign reg_tick   = frame_tick && (state_q == ST_PLAY);
    assign pause_tick = frame_tick && ((state_q == ST_KICKOFF) || (state_q == ST_GOAL_PAUSE));

    frame_down_counter #(.W(FRAME_W)) u_reg_timer (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .load       (load_reg),
        .load_value (MATCH_LOAD),
        .enable     (reg_tick),
        .count      (frames_left),
        .zero       (reg_zero)
    );

    frame_down_counter #(.W(FRAME_W)) u_pause_timer (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .load       (load_pause),
        .load_value (PAUSE_LOAD),
        .enable     (pause_tick),
        .count      (pause_count),
        .zero       (pause_zero)
    );

    // Act on the tick that empties a timer rather than one cycle later.
    assign reg_timeout = reg_zero || (reg_tick && (frames_left == FRAME_W'(1)));
    assign pause_done  = pause_zero || (pause_tick && (pause_count == FRAME_W'(1)));

    // Lowest asserted goal bit wins: scan downwards so the last hit is the lowest.
    always_comb begin
        goal_valid = 1'b0;
        goal_idx   = '0;
        goal_cur   = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (goal[i]) begin
                goal_valid = 1'b1;
                goal_idx   = i[WINNER_W-1:0];
                goal_cur   = score_q[i];
            end
        end
        goal_new  = (goal_cur >= WIN) ? WIN : goal_cur + 1'b1;
        goal_wins = (goal_new == WIN);
    end

    // Timeout decision: a unique leader wins, any tie goes to sudden death.
    always_comb begin
        max_score = '0;
        max_idx   = '0;
        max_count = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (score_q[i] > max_score) begin
                max_score = score_q[i];
                max_idx   = i[WINNER_W-1:0];
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (score_q[i] == max_score) begin
                max_count = max_count + 3'd1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        round_reset_d = 1'b0;
        load_reg      = 1'b0;
        load_pause    = 1'b0;
        clear_scores  = 1'b0;
        credit        = 1'b0;
        set_winner    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear_scores  = 1'b1;
                    load_reg      = 1'b1;
                    load_pause    = 1'b1;
                    round_reset_d = 1'b1;
                    state_d       = ST_KICKOFF;
                end
            end
            ST_KICKOFF: begin
                if (pause_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (goal_valid) begin
                    credit        = 1'b1;
                    round_reset_d = 1'b1;
                    if (goal_wins) begin
                        set_winner = 1'b1;
                        winner_d   = goal_idx;
                        state_d    = ST_GAME_OVER;
                    end else begin
                        load_pause = 1'b1;
                        state_d    = ST_GOAL_PAUSE;
                    end
                end else if (reg_timeout) begin
                    if (max_count == 3'd1) begin
                        set_winner = 1'b1;
                        winner_d   = max_idx;
                        state_d    = ST_GAME_OVER;
                    end else begin
                        state_d = ST_SUDDEN_DEATH;
                    end
                end
            end
            ST_GOAL_PAUSE: begin
                if (pause_done) state_d = ST_PLAY;
            end
            ST_SUDDEN_DEATH: begin
                if (goal_valid) begin
                    credit        = 1'b1;
                    round_reset_d = 1'b1;
                    set_winner    = 1'b1;
                    winner_d      = goal_idx;
                    state_d       = ST_GAME_OVER;
                end
            end
            ST_GAME_OVER: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            winner_q      <= '0;
            round_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_reset_q <= round_reset_d;
            if (clear_scores) begin
                winner_q <= '0;
            end else if (set_winner) begin
                winner_q <= winner_d;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
        end else if (clear_scores) begin
            for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
        end else if (credit) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (goal_idx == i[WINNER_W-1:0]) score_q[i] <= goal_new;
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
        assign score[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    assign state       = state_q;
    assign round_reset = round_reset_q;
    assign winner      = winner_q;
    assign play_en     = (state_q == ST_PLAY) || (state_q == ST_SUDDEN_DEATH);

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - directed self-checking bench for match_controller
module tb_match_controller;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        start;
    logic [1:0]  goal;
    logic [7:0]  score;
    logic [15:0] frames_left;
    logic [2:0]  state;
    logic        round_reset;
    logic        play_en;
    logic [1:0]  winner;

    int compared;
    int mismatched;

    localparam logic [2:0] S_IDLE = 3'd0, S_KICK = 3'd1, S_PLAY = 3'd2,
                           S_PAUSE = 3'd3, S_SD = 3'd4, S_OVER = 3'd5;

    match_controller #(
        .NUM_PLAYERS  (2),
        .SCORE_W      (4),
        .WIN_SCORE    (5),
        .MATCH_FRAMES (3),
        .PAUSE_FRAMES (2)
    ) dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .frame_tick  (frame_tick),
        .start       (start),
        .goal        (goal),
        .score       (score),
        .frames_left (frames_left),
        .state       (state),
        .round_reset (round_reset),
        .play_en     (play_en),
        .winner      (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given goal/frame_tick, then sample 1 ns after the edge.
    task automatic cycle(input logic [1:0] g, input logic ft);
        goal       = g;
        frame_tick = ft;
        @(posedge clk);
        #1;
        goal       = '0;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        goal = '0;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (state !== S_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        compared++; if (score !== 8'h00) begin mismatched++; $display("FAIL reset_score: got %h expected 00", score); end
        compared++; if (frames_left !== 16'd0) begin mismatched++; $display("FAIL reset_frames: got %0d expected 0", frames_left); end
        compared++; if ({round_reset, play_en, winner} !== 4'b0) begin mismatched++; $display("FAIL reset_outputs: got %b expected 0000", {round_reset, play_en, winner}); end
        rst_n = 1'b1;
        cycle(2'b00, 1'b0);
        compared++; if (state !== S_IDLE) begin mismatched++; $display("FAIL idle_hold: got %0d expected %0d", state, S_IDLE); end
    endtask

    task automatic test_kickoff();
        start = 1'b1;
        cycle(2'b00, 1'b0);
        compared++; if (state !== S_KICK) begin mismatched++; $display("FAIL kick_state: got %0d expected %0d", state, S_KICK); end
        compared++; if (round_reset !== 1'b1) begin mismatched++; $display("FAIL kick_rr: got %b expected 1", round_reset); end
        compared++; if (frames_left !== 16'd3) begin mismatched++; $display("FAIL kick_frames: got %0d expected 3", frames_left); end
        cycle(2'b00, 1'b0);
        compared++; if (round_reset !== 1'b0) begin mismatched++; $display("FAIL kick_rr_width: got %b expected 0", round_reset); end
        cycle(2'b01, 1'b1);
        compared++; if (state !== S_KICK) begin mismatched++; $display("FAIL kick_tick1: got %0d expected %0d", state, S_KICK); end
        compared++; if (score !== 8'h00) begin mismatched++; $display("FAIL kick_goal_ignored: got %h expected 00", score); end
        cycle(2'b00, 1'b1);
        compared++; if (state !== S_PLAY) begin mismatched++; $display("FAIL kick_to_play: got %0d expected %0d", state, S_PLAY); end
        compared++; if (play_en !== 1'b1) begin mismatched++; $display("FAIL play_en: got %b expected 1", play_en); end
    endtask

    task automatic test_goal_priority();
        cycle(2'b11, 1'b0);
        compared++; if (score !== 8'h01) begin mismatched++; $display("FAIL prio_score: got %h expected 01", score); end
        compared++; if (round_reset !== 1'b1) begin mismatched++; $display("FAIL prio_rr: got %b expected 1", round_reset); end
        compared++; if (state !== S_PAUSE) begin mismatched++; $display("FAIL prio_state: got %0d expected %0d", state, S_PAUSE); end
        cycle(2'b10, 1'b0);
        compared++; if (round_reset !== 1'b0) begin mismatched++; $display("FAIL prio_rr_width: got %b expected 0", round_reset); end
        compared++; if (score !== 8'h01) begin mismatched++; $display("FAIL pause_goal_ignored: got %h expected 01", score); end
        compared++; if (play_en !== 1'b0) begin mismatched++; $display("FAIL pause_play_en: got %b expected 0", play_en); end
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        compared++; if (state !== S_PLAY) begin mismatched++; $display("FAIL pause_to_play: got %0d expected %0d", state, S_PLAY); end
        compared++; if (frames_left !== 16'd3) begin mismatched++; $display("FAIL pause_frozen: got %0d expected 3", frames_left); end
    endtask

    task automatic test_win();
        for (int k = 0; k < 4; k++) begin
            cycle(2'b10, 1'b0);
            cycle(2'b00, 1'b1);
            cycle(2'b00, 1'b1);
        end
        compared++; if (score !== 8'h41) begin mismatched++; $display("FAIL win_pre_score: got %h expected 41", score); end
        cycle(2'b10, 1'b0);
        compared++; if (state !== S_OVER) begin mismatched++; $display("FAIL win_state: got %0d expected %0d", state, S_OVER); end
        compared++; if (winner !== 2'd1) begin mismatched++; $display("FAIL win_winner: got %0d expected 1", winner); end
        compared++; if (score !== 8'h51) begin mismatched++; $display("FAIL win_score: got %h expected 51", score); end
        cycle(2'b10, 1'b0);
        cycle(2'b01, 1'b1);
        compared++; if (score !== 8'h51) begin mismatched++; $display("FAIL win_hold_score: got %h expected 51", score); end
        compared++; if ({state, winner} !== {S_OVER, 2'd1}) begin mismatched++; $display("FAIL win_hold_state: got %0d/%0d expected 5/1", state, winner); end
        start = 1'b0;
        cycle(2'b00, 1'b0);
        compared++; if (state !== S_IDLE) begin mismatched++; $display("FAIL win_release: got %0d expected %0d", state, S_IDLE); end
    endtask

    task automatic test_sudden_death();
        start = 1'b1;
        cycle(2'b00, 1'b0);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        cycle(2'b01, 1'b0);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        cycle(2'b10, 1'b0);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        compared++; if ({state, score} !== {S_PLAY, 8'h11}) begin mismatched++; $display("FAIL sd_setup: got %0d/%h expected 2/11", state, score); end
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        compared++; if (frames_left !== 16'd1) begin mismatched++; $display("FAIL sd_countdown: got %0d expected 1", frames_left); end
        cycle(2'b00, 1'b1);
        compared++; if (state !== S_SD) begin mismatched++; $display("FAIL sd_state: got %0d expected %0d", state, S_SD); end
        compared++; if (frames_left !== 16'd0) begin mismatched++; $display("FAIL sd_frames: got %0d expected 0", frames_left); end
        cycle(2'b00, 1'b1);
        compared++; if ({frames_left, play_en} !== {16'd0, 1'b1}) begin mismatched++; $display("FAIL sd_freeze: got %0d/%b expected 0/1", frames_left, play_en); end
        cycle(2'b01, 1'b0);
        compared++; if ({state, winner} !== {S_OVER, 2'd0}) begin mismatched++; $display("FAIL sd_winner: got %0d/%0d expected 5/0", state, winner); end
        compared++; if ({score, round_reset} !== {8'h12, 1'b1}) begin mismatched++; $display("FAIL sd_score: got %h/%b expected 12/1", score, round_reset); end
        start = 1'b0;
        cycle(2'b00, 1'b0);
    endtask

    task automatic test_goal_on_final_tick();
        start = 1'b1;
        cycle(2'b00, 1'b0);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        cycle(2'b10, 1'b1);
        compared++; if ({state, score} !== {S_PAUSE, 8'h10}) begin mismatched++; $display("FAIL final_goal: got %0d/%h expected 3/10", state, score); end
        compared++; if (frames_left !== 16'd0) begin mismatched++; $display("FAIL final_frames: got %0d expected 0", frames_left); end
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b0);
        compared++; if (state !== S_OVER) begin mismatched++; $display("FAIL final_state: got %0d expected %0d", state, S_OVER); end
        compared++; if (winner !== 2'd1) begin mismatched++; $display("FAIL final_winner: got %0d expected 1", winner); end
        start = 1'b0;
        cycle(2'b00, 1'b0);
    endtask

    task automatic test_reset_mid_match();
        start = 1'b1;
        cycle(2'b00, 1'b0);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        cycle(2'b01, 1'b0);
        compared++; if (state !== S_PAUSE) begin mismatched++; $display("FAIL mid_setup: got %0d expected %0d", state, S_PAUSE); end
        rst_n = 1'b0;
        #1;
        compared++; if (state !== S_IDLE) begin mismatched++; $display("FAIL mid_async_state: got %0d expected %0d", state, S_IDLE); end
        compared++; if ({score, frames_left} !== 24'd0) begin mismatched++; $display("FAIL mid_async_clear: got %h/%0d expected 00/0", score, frames_left); end
        start = 1'b0;
        cycle(2'b00, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(2'b01, 1'b1);
            compared++; if ({round_reset, state} !== {1'b0, S_IDLE}) begin mismatched++; $display("FAIL mid_no_rr[%0d]: got %b/%0d expected 0/0", k, round_reset, state); end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_kickoff();
        test_goal_priority();
        test_win();
        test_sudden_death();
        test_goal_on_final_tick();
        test_reset_mid_match();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
